ag_w_seq: RTL and testbench

Runtime-configurable weight address generator for the systolic array. It streams temp_buff read addresses and a DPR chip select for each W_i bank. The sequence sweeps an M-word row segment once per bank (P banks), then advances to the next segment (GAMMA segments). Loop bounds and base address are latched at start, output beats use a valid/ready handshake with backpressure, and the block reports completion, last-beat, abort and configuration errors.

---
 rtl/ag_w_seq_pkg.sv | 34 +++
 rtl/ag_w_seq_counter.sv | 34 +++
 rtl/ag_w_seq.sv | 135 +++++++++++++
 tb/tb_ag_w_seq.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ag_w_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ag_pkg
// Description : Shared types for the weight address generator: FSM states,
//               latched configuration record and the legality check.
// Revision    : 1.0 - initial release
// ============================================================================
package ag_pkg;

    localparam int C_ADDR_W = 8;
    localparam int C_CNT_W  = 4;
    localparam int C_P_MAX  = 8;
    localparam int C_CS_W   = $clog2(C_P_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    typedef struct packed {
        logic [C_CNT_W-1:0]  m;
        logic [C_CS_W:0]     p;
        logic [C_CNT_W-1:0]  gamma;
        logic [C_ADDR_W-1:0] base;
    } cfg_t;

    function automatic logic cfg_legal(input cfg_t c);
        return (c.m != '0) && (c.p != '0) && (c.gamma != '0) &&
               (int'(c.p) <= C_P_MAX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ag_w_seq_counter.sv
`default_nettype none
// ============================================================================
// Module      : mod_counter
// Description : Wrapping up-counter with runtime terminal value, enable and
//               synchronous clear; o_wrap flags an enabled step at the max.
// Revision    : 1.0 - initial release
// ============================================================================
module mod_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_max,
    output logic [WIDTH-1:0] o_count,
    output logic             o_wrap
);

    logic [WIDTH-1:0] r_count;

    assign o_wrap  = i_en && (r_count == i_max);
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= o_wrap ? '0 : r_count + WIDTH'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/ag_w_seq.sv
`default_nettype none
// ============================================================================
// Module      : ag_w_seq
// Description : Weight address generator: streams temp_buff addresses and a
//               DPR chip select, word-in-bank-in-segment, over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module ag_w_seq
    import ag_pkg::*;
#(
    parameter int ADDR_W = C_ADDR_W,
    parameter int CNT_W  = C_CNT_W,
    parameter int P_MAX  = C_P_MAX,
    parameter int CS_W   = $clog2(P_MAX)
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  cfg_m,
    input  logic [CS_W:0]     cfg_p,
    input  logic [CNT_W-1:0]  cfg_gamma,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic              rdy,
    output logic              valid,
    output logic [ADDR_W-1:0] addr,
    output logic [CS_W-1:0]   cs,
    output logic [P_MAX-1:0]  cs_oh,
    output logic              last,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t            r_state;
    state_t            w_next;
    cfg_t              w_cfg_in;
    cfg_t              r_cfg;
    logic [ADDR_W-1:0] r_row_off;
    logic              r_err;

    logic [CNT_W-1:0]  w_m_it;
    logic [CNT_W-1:0]  w_g_it;
    logic [CNT_W-1:0]  w_m_max;
    logic [CNT_W-1:0]  w_g_max;
    logic [CS_W-1:0]   w_p_it;
    logic [CS_W-1:0]   w_p_max;
    logic              w_m_wrap;
    logic              w_p_wrap;
    logic              w_g_wrap;
    logic              w_valid;
    logic              w_xfer;
    logic              w_clr;

    assign w_cfg_in = {cfg_m, cfg_p, cfg_gamma, cfg_base};
    assign w_valid  = (r_state == RUN);
    assign w_xfer   = w_valid && rdy;
    assign w_clr    = (r_state != RUN);
    assign w_m_max  = r_cfg.m - CNT_W'(1);
    assign w_g_max  = r_cfg.gamma - CNT_W'(1);
    assign w_p_max  = CS_W'(r_cfg.p - 1'b1);

    mod_counter #(.WIDTH(CNT_W)) u_m_cnt (
        .clk     (sys_clk),
        .rst     (reset),
        .i_clr   (w_clr),
        .i_en    (w_xfer),
        .i_max   (w_m_max),
        .o_count (w_m_it),
        .o_wrap  (w_m_wrap)
    );

    mod_counter #(.WIDTH(CS_W)) u_p_cnt (
        .clk     (sys_clk),
        .rst     (reset),
        .i_clr   (w_clr),
        .i_en    (w_m_wrap),
        .i_max   (w_p_max),
        .o_count (w_p_it),
        .o_wrap  (w_p_wrap)
    );

    mod_counter #(.WIDTH(CNT_W)) u_g_cnt (
        .clk     (sys_clk),
        .rst     (reset),
        .i_clr   (w_clr),
        .i_en    (w_m_wrap && w_p_wrap),
        .i_max   (w_g_max),
        .o_count (w_g_it),
        .o_wrap  (w_g_wrap)
    );

    // w_g_wrap only fires on the transfer of the final beat
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = cfg_legal(w_cfg_in) ? RUN : FIN;
            RUN:     if (abort) w_next = IDLE;
                     else if (w_g_wrap) w_next = FIN;
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cfg     <= '0;
            r_row_off <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && start) begin
                r_cfg     <= w_cfg_in;
                r_row_off <= '0;
                r_err     <= !cfg_legal(w_cfg_in);
            end else if (w_m_wrap && w_p_wrap) begin
                r_row_off <= r_row_off + ADDR_W'(r_cfg.m);
            end
        end
    end

    // Beat fields are forced to zero whenever no beat is presented
    assign valid = w_valid;
    assign addr  = w_valid ? (r_cfg.base + r_row_off + ADDR_W'(w_m_it)) : '0;
    assign cs    = w_valid ? w_p_it : '0;
    assign cs_oh = w_valid ? (P_MAX'(1) << w_p_it) : '0;
    assign last  = w_valid && (w_m_it == w_m_max) && (w_p_it == w_p_max) &&
                   (w_g_it == w_g_max);
    assign busy  = (r_state != IDLE);
    assign done  = (r_state == FIN);
    assign err   = (r_state == FIN) && r_err;

endmodule
`default_nettype wire

// File: tb/tb_ag_w_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_ag_w_seq
// Description : Self-checking bench for ag_w_seq: table of configurations
//               plus directed abort / reset / mid-run start sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ag_w_seq;

    logic       sys_clk   = 1'b0;
    logic       reset     = 1'b1;
    logic       start     = 1'b0;
    logic       abort     = 1'b0;
    logic       rdy       = 1'b1;
    logic [3:0] cfg_m     = '0;
    logic [3:0] cfg_p     = '0;
    logic [3:0] cfg_gamma = '0;
    logic [7:0] cfg_base  = '0;

    logic       valid;
    logic [7:0] addr;
    logic [2:0] cs;
    logic [7:0] cs_oh;
    logic       last;
    logic       busy;
    logic       done;
    logic       err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int m;
        int p;
        int g;
        int base;
        bit bp;
        bit exp_err;
        int exp_beats;
        int exp_last;
    } vec_t;

    vec_t vecs[8];

    ag_w_seq u_dut (
        .sys_clk   (sys_clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .cfg_m     (cfg_m),
        .cfg_p     (cfg_p),
        .cfg_gamma (cfg_gamma),
        .cfg_base  (cfg_base),
        .rdy       (rdy),
        .valid     (valid),
        .addr      (addr),
        .cs        (cs),
        .cs_oh     (cs_oh),
        .last      (last),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Runs one full sequence from IDLE and checks every beat against a
    // nested-loop reference; returns at #1 after the edge in IDLE.
    task automatic run_seq(input vec_t v, output int beats, output int last_addr);
        int          gi    = 0;
        int          pi    = 0;
        int          mi    = 0;
        int          cyc   = 0;
        int          total;
        bit          fin   = 1'b0;
        bit          held  = 1'b0;
        logic [31:0] hv    = '0;
        logic [31:0] cur;
        logic [31:0] expv;
        logic [7:0]  ea;
        total     = v.m * v.p * v.g;
        beats     = 0;
        last_addr = -1;
        cfg_m     = 4'(v.m);
        cfg_p     = 4'(v.p);
        cfg_gamma = 4'(v.g);
        cfg_base  = 8'(v.base);
        start     = 1'b1;
        tick();
        start     = 1'b0;
        // the sequence must keep using the values captured at start
        cfg_m     = 4'd3;
        cfg_p     = 4'd1;
        cfg_gamma = 4'd1;
        cfg_base  = 8'hA5;
        if (v.exp_err) begin
            check("err_pulse", {valid, busy, done, err}, 4'b0111);
            tick();
            check("err_idle", {valid, busy, done, err}, 4'b0000);
            return;
        end
        check("first_beat", {valid, addr, cs}, {1'b1, 8'(v.base), 3'd0});
        while (!fin && cyc < 4000) begin
            cur = {11'd0, valid, addr, cs, cs_oh, last};
            if (held) check("hold", cur, hv);
            ea   = 8'(v.base + gi * v.m + mi);
            expv = {11'd0, 1'b1, ea, 3'(pi), 8'(1 << pi), (beats == total - 1)};
            check("beat", cur, expv);
            rdy = v.bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (valid && rdy) begin
                last_addr = int'(addr);
                beats++;
                mi++;
                if (mi == v.m) begin
                    mi = 0;
                    pi++;
                    if (pi == v.p) begin
                        pi = 0;
                        gi++;
                    end
                end
                if (beats == total) fin = 1'b1;
                held = 1'b0;
            end else begin
                held = valid;
                hv   = cur;
            end
            tick();
            cyc++;
        end
        rdy = 1'b1;
        check("seq_timeout", 32'(fin), 32'd1);
        check("done_pulse", {valid, busy, done, err}, 4'b0110);
        tick();
        check("back_idle", {valid, busy, done, err}, 4'b0000);
    endtask

    initial begin
        int beats;
        int last_addr;

        vecs[0] = '{9, 4, 3, 0,   1'b0, 1'b0, 108, 26};
        vecs[1] = '{9, 4, 3, 0,   1'b1, 1'b0, 108, 26};
        vecs[2] = '{4, 1, 2, 250, 1'b0, 1'b0, 8,   1};
        vecs[3] = '{9, 4, 0, 0,   1'b0, 1'b1, 0,   0};
        vecs[4] = '{9, 9, 3, 0,   1'b0, 1'b1, 0,   0};
        vecs[5] = '{0, 2, 2, 0,   1'b0, 1'b1, 0,   0};
        vecs[6] = '{2, 8, 1, 16,  1'b1, 1'b0, 16,  17};
        vecs[7] = '{15, 0, 1, 0,  1'b0, 1'b1, 0,   0};

        repeat (3) tick();
        check("reset_state", {valid, addr, cs, cs_oh, last, busy, done, err}, 32'd0);
        reset = 1'b0;
        tick();

        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_in_idle", {valid, busy, done, err}, 4'b0000);

        foreach (vecs[i]) begin
            run_seq(vecs[i], beats, last_addr);
            check("beat_count", 32'(beats), 32'(vecs[i].exp_beats));
            if (!vecs[i].exp_err) check("last_addr", 32'(last_addr), 32'(vecs[i].exp_last));
        end

        // abort at beat 17 with a stray start at beat 5
        cfg_m = 4'd9; cfg_p = 4'd4; cfg_gamma = 4'd3; cfg_base = 8'd0;
        start = 1'b1;
        tick();
        start    = 1'b0;
        cfg_base = 8'd200;
        for (int k = 0; k <= 17; k++) begin
            check("abort_run", {valid, addr, cs},
                  {1'b1, 8'((k / 36) * 9 + k % 9), 3'((k / 9) % 4)});
            start = (k == 5);
            abort = (k == 17);
            tick();
        end
        start = 1'b0;
        abort = 1'b0;
        check("abort_idle", {valid, busy, done, err}, 4'b0000);
        tick();
        check("abort_nodone", {valid, busy, done, err}, 4'b0000);
        run_seq('{2, 2, 1, 100, 1'b0, 1'b0, 4, 101}, beats, last_addr);
        check("restart_beats", 32'(beats), 32'd4);
        check("restart_last", 32'(last_addr), 32'd101);

        // abort coinciding with the final transfer: abort wins
        cfg_m = 4'd1; cfg_p = 4'd1; cfg_gamma = 4'd1; cfg_base = 8'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("single_last", {valid, last, addr}, {1'b1, 1'b1, 8'd9});
        abort = 1'b1;
        rdy   = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_last", {valid, busy, done, err}, 4'b0000);
        tick();
        check("abort_last_nodone", {valid, busy, done, err}, 4'b0000);

        // reset in the middle of a run
        cfg_m = 4'd9; cfg_p = 4'd4; cfg_gamma = 4'd3; cfg_base = 8'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        reset = 1'b1;
        tick();
        check("reset_midrun", {valid, addr, cs, cs_oh, last, busy, done, err}, 32'd0);
        reset = 1'b0;
        run_seq('{3, 2, 2, 7, 1'b0, 1'b0, 12, 12}, beats, last_addr);
        check("post_reset_beats", 32'(beats), 32'd12);
        check("post_reset_last", 32'(last_addr), 32'd12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
